// File: rtl/alu_result_stage.sv
// ALU result stage: selects the final ALU result, derives zero/overflow and the
// gated register-write flag, and buffers each result in a 2-entry FIFO with a
// valid/ready handshake on both sides.
module alu_result_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ANDOut,
  input  logic [DATA_W-1:0] OROut,
  input  logic [DATA_W-1:0] FAOut,
  input  logic [DATA_W-1:0] SLTOut,
  input  logic              a_msb,
  input  logic              b_msb,
  input  logic [DATA_W-1:0] shift_src,
  input  logic [4:0]        shamt,
  input  logic [2:0]        sel,
  input  logic [4:0]        rd_in,
  input  logic              regwrite_in,
  input  logic              in_valid,
  input  logic              flush,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              ovf,
  output logic [4:0]        rd_out,
  output logic              regwrite_out
);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;

  // Entry layout, MSB first: {result, zero, ovf, rd, regwrite}
  localparam int ENT_W = DATA_W + 8;

  logic [DATA_W-1:0] sel_result;
  logic              sel_zero;
  logic              sel_ovf;
  logic              sel_regwrite;
  logic [ENT_W-1:0]  new_entry;

  logic [ENT_W-1:0]  mem_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push, pop;
  logic [ENT_W-1:0]  head;

  // Result mux and overflow detection for the incoming operation
  always_comb begin
    sel_result = '0;
    sel_ovf    = 1'b0;
    case (sel)
      OP_AND: sel_result = ANDOut;
      OP_OR:  sel_result = OROut;
      OP_ADD: begin
        sel_result = FAOut;
        sel_ovf    = (a_msb == b_msb) && (FAOut[DATA_W-1] != a_msb);
      end
      OP_SUB: begin
        sel_result = FAOut;
        sel_ovf    = (a_msb != b_msb) && (FAOut[DATA_W-1] != a_msb);
      end
      OP_SLT: sel_result = SLTOut;
      OP_SLL: sel_result = shift_src << shamt;
      OP_SRL: sel_result = shift_src >> shamt;
      default: sel_result = '0;
    endcase
  end

  // An overflowing op or a NOP must never write the register file
  assign sel_zero     = (sel_result == '0);
  assign sel_regwrite = regwrite_in && !sel_ovf && (sel != 3'd7);
  assign new_entry    = {sel_result, sel_zero, sel_ovf, rd_in, sel_regwrite};

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state for count and pointers; flush overrides any push or pop
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; writes are dropped on a flush cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  // Head outputs are forced to zero while the buffer is empty so that reset
  // and flush both present a clean all-zero output bundle
  assign head         = out_valid ? mem_q[rd_ptr_q] : '0;
  assign result       = head[ENT_W-1 -: DATA_W];
  assign zero         = head[7];
  assign ovf          = head[6];
  assign rd_out       = head[5:1];
  assign regwrite_out = head[0];

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: directed scenarios plus random traffic,
// compared against a queue-based behavioural model of the result buffer.
module tb_alu_result_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] ANDOut, OROut, FAOut, SLTOut, shift_src;
  logic        a_msb, b_msb;
  logic [4:0]  shamt;
  logic [2:0]  sel;
  logic [4:0]  rd_in;
  logic        regwrite_in, in_valid, flush, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] result;
  logic        zero, ovf, regwrite_out;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic [4:0]  rd;
    logic        rw;
  } entry_t;

  entry_t model_q[$];

  alu_result_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ANDOut(ANDOut), .OROut(OROut), .FAOut(FAOut), .SLTOut(SLTOut),
    .a_msb(a_msb), .b_msb(b_msb), .shift_src(shift_src), .shamt(shamt),
    .sel(sel), .rd_in(rd_in), .regwrite_in(regwrite_in),
    .in_valid(in_valid), .flush(flush), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .rd_out(rd_out),
    .regwrite_out(regwrite_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: what the stage should store for the current inputs
  function automatic entry_t model_entry();
    entry_t e;
    logic   same_sign;
    e.res = 32'd0;
    e.o   = 1'b0;
    case (sel)
      3'd0: e.res = ANDOut;
      3'd1: e.res = OROut;
      3'd2, 3'd3: e.res = FAOut;
      3'd4: e.res = SLTOut;
      3'd5: e.res = shift_src << shamt;
      3'd6: e.res = shift_src >> shamt;
      default: e.res = 32'd0;
    endcase
    // two's-complement overflow: effective operand signs agree, result sign differs
    same_sign = (sel == 3'd2) ? (a_msb == b_msb) : (a_msb == !b_msb);
    if (sel == 3'd2 || sel == 3'd3) e.o = same_sign && (FAOut[31] != a_msb);
    e.z  = (e.res == 32'd0);
    e.rd = rd_in;
    e.rw = regwrite_in && !e.o && (sel != 3'd7);
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, ".out_valid"}, 32'(out_valid), 32'(model_q.size() != 0));
    check_val({tag, ".in_ready"},  32'(in_ready),  32'(model_q.size() < 2));
    if (model_q.size() != 0) begin
      check_val({tag, ".result"},   result,             model_q[0].res);
      check_val({tag, ".zero"},     32'(zero),          32'(model_q[0].z));
      check_val({tag, ".ovf"},      32'(ovf),           32'(model_q[0].o));
      check_val({tag, ".rd_out"},   32'(rd_out),        32'(model_q[0].rd));
      check_val({tag, ".regwrite"}, 32'(regwrite_out),  32'(model_q[0].rw));
    end
  endtask

  // One clock: inputs already driven; update model at the edge, check at negedge
  task automatic tick(input string tag);
    entry_t e;
    bit     do_push, do_pop;
    e       = model_entry();
    do_push = in_valid && (model_q.size() < 2);
    do_pop  = out_ready && (model_q.size() > 0);
    @(posedge clk);
    if (flush) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    @(negedge clk);
    $display("cycle %s: sel=%0d in_v=%0b out_r=%0b flush=%0b -> count=%0d out_valid=%0b result=0x%08h",
             tag, sel, in_valid, out_ready, flush, model_q.size(), out_valid, result);
    check_outputs(tag);
  endtask

  task automatic set_op(input logic [2:0] s, input logic [31:0] fa, input logic am, input logic bm);
    sel = s; FAOut = fa; a_msb = am; b_msb = bm;
  endtask

  initial begin
    rst_n = 1'b0;
    {ANDOut, OROut, FAOut, SLTOut, shift_src} = '0;
    {a_msb, b_msb, shamt, sel, rd_in, regwrite_in} = '0;
    {in_valid, flush, out_ready} = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_val("rst.out_valid", 32'(out_valid), 32'd0);
    check_val("rst.in_ready",  32'(in_ready),  32'd1);
    check_val("rst.result",    result,         32'd0);
    check_val("rst.flags", 32'({zero, ovf, rd_out, regwrite_out}), 32'd0);
    rst_n = 1'b1;

    // Simple ADD, one-cycle latency
    set_op(3'd2, 32'h5, 1'b0, 1'b0);
    rd_in = 5'd3; regwrite_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick("add5");
    check_val("add5.result", result, 32'h5);

    // Signed ADD overflow suppresses regwrite
    set_op(3'd2, 32'h8000_0000, 1'b0, 1'b0);
    tick("add_ovf");
    check_val("add_ovf.ovf", 32'(ovf), 32'd1);
    check_val("add_ovf.regwrite", 32'(regwrite_out), 32'd0);

    // SRL by 31 and SUB giving zero
    sel = 3'd6; shift_src = 32'h8000_0000; shamt = 5'd31;
    tick("srl31");
    check_val("srl31.result", result, 32'h1);
    set_op(3'd3, 32'h0, 1'b1, 1'b1);
    tick("sub_zero");
    check_val("sub_zero.zero", 32'(zero), 32'd1);

    // Backpressure: three pushes with out_ready low, then drain in order
    in_valid = 1'b0;
    tick("drain");
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(3'd2, 32'h100 + 32'(i), 1'b0, 1'b0);
      rd_in = 5'(i + 10);
      tick($sformatf("bp_push%0d", i));
    end
    check_val("bp.in_ready_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    check_val("bp.head0", result, 32'h100);
    tick("bp_pop0");
    check_val("bp.head1", result, 32'h101);
    tick("bp_pop1");

    // Flush while full with an incoming push
    out_ready = 1'b0; in_valid = 1'b1;
    tick("fl_fill0");
    tick("fl_fill1");
    flush = 1'b1;
    tick("flush");
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush.out_valid", 32'(out_valid), 32'd0);
    check_val("flush.in_ready",  32'(in_ready),  32'd1);

    // Asynchronous reset between edges with one entry held
    in_valid = 1'b1;
    set_op(3'd1, 32'h0, 1'b0, 1'b0); OROut = 32'hdead_beef;
    tick("pre_rst");
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    check_val("arst.out_valid", 32'(out_valid), 32'd0);
    check_val("arst.result",    result,         32'd0);
    check_val("arst.flags", 32'({zero, ovf, rd_out, regwrite_out}), 32'd0);
    check_val("arst.in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    tick("post_rst");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      ANDOut = $urandom; OROut = $urandom; SLTOut = 32'($urandom_range(0, 1));
      FAOut = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      shift_src = $urandom; shamt = 5'($urandom);
      a_msb = 1'($urandom); b_msb = 1'($urandom);
      sel = 3'($urandom); rd_in = 5'($urandom); regwrite_in = 1'($urandom);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      tick($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: datapath width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have ports ANDOut, OROut, FAOut, SLTOut, input, 32 bits each: ALU slice outputs from the upstream ripple-carry ALU.
REQ-005 SHALL have ports a_msb and b_msb, input, 1 bit each: bit 31 of the ALU operands, used for overflow detection.
REQ-006 SHALL have port shift_src, input, 32 bits: shift operand (dataB); and port shamt, input, 5 bits: shift amount.
REQ-007 SHALL have port sel, input, 3 bits: operation select; 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 SLL, 6 SRL, 7 NOP.
REQ-008 SHALL have port rd_in, input, 5 bits: destination register; and port regwrite_in, input, 1 bit.
REQ-009 SHALL have input handshake ports in_valid and flush (1 bit each) and output port in_ready (1 bit).
REQ-010 SHALL have output handshake ports out_valid (1 bit) and input port out_ready (1 bit).
REQ-011 SHALL have outputs result (32 bits), zero (1 bit), ovf (1 bit), rd_out (5 bits) and regwrite_out (1 bit), all driven from the buffer head entry.

Function
REQ-012 SHALL compute result selection combinationally: AND->ANDOut; OR->OROut; ADD/SUB->FAOut; SLT->SLTOut; SLL->shift_src<<shamt; SRL->shift_src>>shamt (logical, zero fill); NOP->0.
REQ-013 SHALL compute ovf as: for ADD, a_msb==b_msb and FAOut[31]!=a_msb; for SUB, a_msb!=b_msb and FAOut[31]!=a_msb; for all other ops, 0.
REQ-014 SHALL compute stored regwrite as regwrite_in AND NOT ovf AND (sel!=7).
REQ-015 SHALL compute zero as (selected result == 0).
REQ-016 SHALL store each entry as {result, zero, ovf, rd, regwrite} in a 2-entry FIFO with a 2-bit count (0..2).
REQ-017 SHALL drive in_ready = (count < 2), combinational from count only.
REQ-018 SHALL push an entry on a cycle where in_valid and in_ready are both 1.
REQ-019 SHALL pop the head entry on a cycle where out_valid and out_ready are both 1.
REQ-020 SHALL drive out_valid = (count != 0).
REQ-021 SHALL have a latency of 1 cycle: an entry accepted at edge N is visible on the outputs after edge N when the FIFO was empty.
REQ-022 SHALL, on simultaneous push and pop with count 1, keep count at 1 and make the new entry the head.
REQ-023 SHALL keep count 0 on simultaneous push and pop at count 0; no pop occurs since out_valid=0.
REQ-024 SHALL, when count is 2, deassert in_ready; a pop that cycle frees one slot, which becomes usable from the next cycle.
REQ-025 SHALL keep head outputs stable while out_valid=1 and out_ready=0.
REQ-026 SHALL treat flush (synchronous, highest priority) as: count becomes 0 at the next edge; the same-cycle push and pop are discarded.
REQ-027 SHALL hold the FIFO pointers modulo 2 and wrap without data loss.

Reset
REQ-028 SHALL, while rst_n=0, immediately force count=0, out_valid=0, result=0, zero=0, ovf=0, rd_out=0 and regwrite_out=0, with in_ready=1.
REQ-029 SHALL discard any in-flight entries on reset asserted mid-operation; the first push after reset release is accepted normally.

Verification
REQ-030 SHALL cover: sel=2, FAOut=0x00000005, in_valid=1, out_ready=1 -> next cycle result=5, zero=0, ovf=0, out_valid=1.
REQ-031 SHALL cover: sel=2, a_msb=0, b_msb=0, FAOut=0x80000000, regwrite_in=1 -> ovf=1, regwrite_out=0.
REQ-032 SHALL cover: sel=6, shift_src=0x80000000, shamt=31 -> result=0x00000001; sel=3 with FAOut=0 -> zero=1.
REQ-033 SHALL cover: out_ready=0 with 3 consecutive pushes -> in_ready=0 after 2 pushes, the third push is held; then out_ready=1 -> entries are popped in order.
REQ-034 SHALL cover: count=2 with flush=1 and in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-035 SHALL cover: rst_n driven low between clock edges with count=1 -> out_valid=0 immediately, and all outputs=0.
